top_control_unit: RTL and testbench

- Self-contained 16-bit multi-cycle processor with a 512x16 instruction RAM (IRAM), a 512x16 data RAM (DRAM), registers, ALU and FSM control unit.
- External mode inputs let a host preload IRAM and DRAM, run a program, then read DRAM results back.
- Intended as the top of the simple-processor FPGA design, for matrix-style workloads.

---
 rtl/top_control_pkg.sv | 60 ++++++
 rtl/simple_ram.sv | 21 ++
 rtl/top_control_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_top_control_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/top_control_pkg.sv
// Shared constants for top_control_unit: opcodes, FSM state codes, control-word
// bit positions, ALU select codes and default memory geometry.
package top_control_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;
    localparam int CTRL_W     = 20;

    typedef enum logic [5:0] {
        S_IDLE     = 6'd0,
        S_FETCH    = 6'd1,
        S_FETCH_W  = 6'd2,
        S_DECODE   = 6'd3,
        S_EXEC     = 6'd4,
        S_MEM_RD   = 6'd5,
        S_MEM_RD_W = 6'd6,
        S_MEM_WR   = 6'd7,
        S_HALT     = 6'd8
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LDAR  = 4'h2;
    localparam logic [3:0] OP_LDAC  = 4'h3;
    localparam logic [3:0] OP_STAC  = 4'h4;
    localparam logic [3:0] OP_INCAR = 4'h5;
    localparam logic [3:0] OP_MVRAC = 4'h6;
    localparam logic [3:0] OP_MVACR = 4'h7;
    localparam logic [3:0] OP_ADD   = 4'h8;
    localparam logic [3:0] OP_SUB   = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JZ    = 4'hC;
    localparam logic [3:0] OP_JNZ   = 4'hD;
    localparam logic [3:0] OP_DEC   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALU select codes carried in control_out[3:0]
    localparam logic [3:0] ALU_PASS_A = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_MUL    = 4'd3;
    localparam logic [3:0] ALU_PASS_B = 4'd4;
    localparam logic [3:0] ALU_IMM    = 4'd5;
    localparam logic [3:0] ALU_MEM    = 4'd6;

    localparam int CB_ALU_LSB  = 0;
    localparam int CB_PC_INC   = 4;
    localparam int CB_PC_LOAD  = 5;
    localparam int CB_AR_LOAD  = 6;
    localparam int CB_AR_INC   = 7;
    localparam int CB_AC_LOAD  = 8;
    localparam int CB_R_LOAD   = 9;
    localparam int CB_IR_LOAD  = 10;
    localparam int CB_DRAM_WE  = 11;
    localparam int CB_DRAM_RE  = 12;
    localparam int CB_IRAM_RE  = 13;
    localparam int CB_Z_LOAD   = 14;

endpackage

// File: rtl/simple_ram.sv
// Single-port synchronous RAM, one-cycle read latency; read data holds when re is low.
module simple_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/top_control_unit.sv
// 16-bit multi-cycle processor with IRAM/DRAM and host load/read modes.
// Optional macro TOP_CONTROL_MUL_EN enables the MUL opcode (otherwise MUL is a NOP).
//   state      | meaning
//   IDLE(0)    | waiting for start, PC held at PC_START
//   FETCH(1)   | IRAM read at PC
//   FETCH_W(2) | latch IR, PC+1
//   DECODE(3)  | choose execute path
//   EXEC(4)    | register/ALU/jump instructions
//   MEM_RD(5)  | DRAM read at AR
//   MEM_RD_W(6)| AC <= DRAM data
//   MEM_WR(7)  | DRAM[AR] <= AC
//   HALT(8)    | hold until start drops
module top_control_unit
    import top_control_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int PC_START = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_2,
    input  logic              start_3,
    input  logic              start_4,
    input  logic [ADDR_W-1:0] addr_ext,
    input  logic              iram_write_ext,
    input  logic              dram_write_ext,
    input  logic              read_en_ext,
    input  logic [DATA_W-1:0] Data_in_ins,
    input  logic [DATA_W-1:0] Data_in_dram,
    output logic [DATA_W-1:0] dram_in,
    output logic [DATA_W-1:0] iram_in,
    output logic [DATA_W-1:0] dram_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] ar_out,
    output logic [CTRL_W-1:0] control_out,
    output logic [5:0]        state,
    output logic [DATA_W-1:0] data_in_pc,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    output logic [DATA_W-1:0] alu_out,
    output logic              write_en,
    output logic [1:0]        read_en
);

    state_t              state_q, state_next;
    logic [3:0]          ir_op;
    logic [ADDR_W-1:0]   ir_imm;
    logic [DATA_W-1:0]   pc, ar, ac, r, imm;
    logic                z;
    logic                ext_mode;

    logic [3:0] alu_sel;
    logic pc_inc, pc_load, ar_load, ar_inc, ac_wr, r_load, ir_load;
    logic dram_we, dram_re, iram_re, z_load;
    logic [CTRL_W-1:0] ctrl;

    logic              iram_we_m, iram_re_m, dram_we_m, dram_re_m;
    logic [ADDR_W-1:0] iram_addr, dram_addr;
    logic [DATA_W-1:0] iram_rdata, dram_rdata, dram_wdata;

    assign ext_mode = start_2 | start_3 | start_4;
    assign imm      = DATA_W'(ir_imm);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:     if (start) state_next = S_FETCH;
            S_FETCH:    state_next = S_FETCH_W;
            S_FETCH_W:  state_next = S_DECODE;
            S_DECODE: begin
                case (ir_op)
                    OP_LDAC: state_next = S_MEM_RD;
                    OP_STAC: state_next = S_MEM_WR;
                    OP_HALT: state_next = S_HALT;
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC:     state_next = S_FETCH;
            S_MEM_RD:   state_next = S_MEM_RD_W;
            S_MEM_RD_W: state_next = S_FETCH;
            S_MEM_WR:   state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_IDLE;
        endcase
        // host modes and a dropped start both take the bus back immediately
        if (ext_mode || !start) state_next = S_IDLE;
    end

    always_comb begin
        alu_sel = ALU_PASS_A;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        ar_load = 1'b0;
        ar_inc  = 1'b0;
        ac_wr   = 1'b0;
        r_load  = 1'b0;
        ir_load = 1'b0;
        dram_we = 1'b0;
        dram_re = 1'b0;
        iram_re = 1'b0;
        case (state_q)
            S_FETCH:   iram_re = 1'b1;
            S_FETCH_W: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            S_EXEC: begin
                case (ir_op)
                    OP_LDI:   begin alu_sel = ALU_IMM;    ac_wr = 1'b1; end
                    OP_LDAR:  ar_load = 1'b1;
                    OP_INCAR: ar_inc  = 1'b1;
                    OP_MVRAC: r_load  = 1'b1;
                    OP_MVACR: begin alu_sel = ALU_PASS_B; ac_wr = 1'b1; end
                    OP_ADD:   begin alu_sel = ALU_ADD;    ac_wr = 1'b1; end
                    OP_SUB:   begin alu_sel = ALU_SUB;    ac_wr = 1'b1; end
                    OP_DEC:   begin alu_sel = ALU_SUB;    ac_wr = 1'b1; end
                    OP_MUL: begin
`ifdef TOP_CONTROL_MUL_EN
                        alu_sel = ALU_MUL;
                        ac_wr   = 1'b1;
`endif
                    end
                    OP_JMP:   pc_load = 1'b1;
                    OP_JZ:    pc_load = z;
                    OP_JNZ:   pc_load = !z;
                    default:  ;
                endcase
            end
            S_MEM_RD:   dram_re = 1'b1;
            S_MEM_RD_W: begin alu_sel = ALU_MEM; ac_wr = 1'b1; end
            S_MEM_WR:   dram_we = 1'b1;
            default:    ;
        endcase
        z_load = ac_wr;
    end

    always_comb begin
        ctrl                     = '0;
        ctrl[CB_ALU_LSB +: 4]    = alu_sel;
        ctrl[CB_PC_INC]          = pc_inc;
        ctrl[CB_PC_LOAD]         = pc_load;
        ctrl[CB_AR_LOAD]         = ar_load;
        ctrl[CB_AR_INC]          = ar_inc;
        ctrl[CB_AC_LOAD]         = ac_wr;
        ctrl[CB_R_LOAD]          = r_load;
        ctrl[CB_IR_LOAD]         = ir_load;
        ctrl[CB_DRAM_WE]         = dram_we;
        ctrl[CB_DRAM_RE]         = dram_re;
        ctrl[CB_IRAM_RE]         = iram_re;
        ctrl[CB_Z_LOAD]          = z_load;
    end

    assign alu_in_1 = ac;
    assign alu_in_2 = (ir_op == OP_DEC || ir_op == OP_INCAR) ? DATA_W'(1) : r;

    always_comb begin
        alu_out = alu_in_1;
        case (alu_sel)
            ALU_ADD:    alu_out = alu_in_1 + alu_in_2;
            ALU_SUB:    alu_out = alu_in_1 - alu_in_2;
`ifdef TOP_CONTROL_MUL_EN
            ALU_MUL:    alu_out = alu_in_1 * alu_in_2;
`endif
            ALU_PASS_B: alu_out = alu_in_2;
            ALU_IMM:    alu_out = imm;
            ALU_MEM:    alu_out = dram_rdata;
            default:    alu_out = alu_in_1;
        endcase
    end

    assign data_in_pc = pc_load ? imm : pc + DATA_W'(1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= DATA_W'(PC_START);
            ar     <= '0;
            ac     <= '0;
            r      <= '0;
            ir_op  <= '0;
            ir_imm <= '0;
            z      <= 1'b0;
        end else begin
            if (state_next == S_IDLE)    pc <= DATA_W'(PC_START);
            else if (pc_inc || pc_load)  pc <= data_in_pc;
            if (ir_load) begin
                ir_op  <= iram_rdata[DATA_W-1 -: 4];
                ir_imm <= iram_rdata[ADDR_W-1:0];
            end
            if (ar_load)     ar <= imm;
            else if (ar_inc) ar <= ar + DATA_W'(1);
            if (ac_wr)  ac <= alu_out;
            if (z_load) z  <= (alu_out == '0);
            if (r_load) r  <= ac;
        end
    end

    // bus ownership: start_2 > start_3 > start_4 > processor
    always_comb begin
        iram_we_m = 1'b0;
        iram_re_m = 1'b0;
        iram_addr = pc[ADDR_W-1:0];
        if (start_2) begin
            iram_we_m = iram_write_ext;
            iram_re_m = 1'b1;
            iram_addr = addr_ext;
        end else if (!ext_mode) begin
            iram_re_m = iram_re;
        end
    end

    always_comb begin
        dram_we_m  = 1'b0;
        dram_re_m  = 1'b0;
        dram_addr  = ar[ADDR_W-1:0];
        dram_wdata = ac;
        if (start_2) begin
            dram_addr = addr_ext;
        end else if (start_3) begin
            dram_we_m  = dram_write_ext;
            dram_addr  = addr_ext;
            dram_wdata = Data_in_dram;
        end else if (start_4) begin
            dram_re_m = read_en_ext;
            dram_addr = addr_ext;
        end else begin
            dram_we_m = dram_we;
            dram_re_m = dram_re;
        end
    end

    simple_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_iram (
        .clock (clock),
        .we    (iram_we_m),
        .re    (iram_re_m),
        .addr  (iram_addr),
        .wdata (Data_in_ins),
        .rdata (iram_rdata)
    );

    simple_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dram (
        .clock (clock),
        .we    (dram_we_m),
        .re    (dram_re_m),
        .addr  (dram_addr),
        .wdata (dram_wdata),
        .rdata (dram_rdata)
    );

    assign dram_in     = dram_rdata;
    assign iram_in     = iram_rdata;
    assign dram_out    = ac;
    assign pc_out      = pc;
    assign ar_out      = ar;
    assign control_out = ctrl;
    assign state       = state_q;
    assign write_en    = ctrl[CB_DRAM_WE];
    assign read_en     = {ctrl[CB_DRAM_RE], ctrl[CB_IRAM_RE]};

endmodule

// File: tb/tb_top_control_unit.sv
// Bench for top_control_unit: table-driven memory load/readback plus program runs.
module tb_top_control_unit;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, start_2 = 1'b0, start_3 = 1'b0, start_4 = 1'b0;
    logic [8:0]  addr_ext = '0;
    logic        iram_write_ext = 1'b0, dram_write_ext = 1'b0, read_en_ext = 1'b0;
    logic [15:0] Data_in_ins = '0, Data_in_dram = '0;
    logic [15:0] dram_in, iram_in, dram_out, pc_out, ar_out;
    logic [19:0] control_out;
    logic [5:0]  state;
    logic [15:0] data_in_pc, alu_in_1, alu_in_2, alu_out;
    logic        write_en;
    logic [1:0]  read_en;

    always #5 clock = ~clock;

    top_control_unit dut (
        .clock(clock), .rst_n(rst_n), .start(start), .start_2(start_2),
        .start_3(start_3), .start_4(start_4), .addr_ext(addr_ext),
        .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
        .read_en_ext(read_en_ext), .Data_in_ins(Data_in_ins),
        .Data_in_dram(Data_in_dram), .dram_in(dram_in), .iram_in(iram_in),
        .dram_out(dram_out), .pc_out(pc_out), .ar_out(ar_out),
        .control_out(control_out), .state(state), .data_in_pc(data_in_pc),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_out(alu_out),
        .write_en(write_en), .read_en(read_en)
    );

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } mem_vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] prog [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic iram_wr(input logic [8:0] a, input logic [15:0] d);
        @(negedge clock);
        start_2 = 1'b1; addr_ext = a; Data_in_ins = d; iram_write_ext = 1'b1;
        @(negedge clock);
        iram_write_ext = 1'b0; start_2 = 1'b0;
    endtask

    task automatic dram_wr(input logic [8:0] a, input logic [15:0] d);
        @(negedge clock);
        start_3 = 1'b1; addr_ext = a; Data_in_dram = d; dram_write_ext = 1'b1;
        @(negedge clock);
        dram_write_ext = 1'b0; start_3 = 1'b0;
    endtask

    task automatic iram_rd_check(input string name, input logic [8:0] a, input logic [15:0] exp);
        @(negedge clock);
        start_2 = 1'b1; iram_write_ext = 1'b0; addr_ext = a;
        exp_q.push_back(exp);
        @(negedge clock);
        start_2 = 1'b0;
        check(name, iram_in, exp_q.pop_front());
    endtask

    task automatic dram_rd_check(input string name, input logic [8:0] a, input logic [15:0] exp);
        @(negedge clock);
        start_4 = 1'b1; read_en_ext = 1'b1; addr_ext = a;
        exp_q.push_back(exp);
        @(negedge clock);
        read_en_ext = 1'b0; start_4 = 1'b0;
        check(name, dram_in, exp_q.pop_front());
    endtask

    task automatic load_prog();
        for (int i = 0; i < 8; i++) iram_wr(9'(i + 1), prog[i]);
    endtask

    task automatic run_until(input string name, input logic [5:0] target, input int budget);
        int n;
        @(negedge clock);
        start = 1'b1;
        n = 0;
        while (state != target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, state, target);
    endtask

    initial begin
        mem_vec_t dvec [6];
        mem_vec_t ivec [3];

        ivec[0] = '{9'd1, 16'h1005, 16'h1005};
        ivec[1] = '{9'd2, 16'h6000, 16'h6000};
        ivec[2] = '{9'd3, 16'hF000, 16'hF000};

        dvec[0] = '{9'd1,   16'h0007, 16'h0007};
        dvec[1] = '{9'd0,   16'hFFFF, 16'hFFFF};
        dvec[2] = '{9'd511, 16'hA5A5, 16'hA5A5};
        dvec[3] = '{9'd256, 16'h0001, 16'hBEEF};
        dvec[4] = '{9'd256, 16'hBEEF, 16'hBEEF};
        dvec[5] = '{9'd2,   16'h8000, 16'h8000};

        #1 rst_n = 1'b0;
        #3;
        check("rst_pc", pc_out, 16'd1);
        check("rst_state", state, 6'd0);
        check("rst_ctrl", control_out, 20'd0);
        check("rst_ar", ar_out, 16'd0);
        check("rst_ac", dram_out, 16'd0);
        @(negedge clock);
        rst_n = 1'b1;

        foreach (ivec[i]) iram_wr(ivec[i].addr, ivec[i].wdata);
        foreach (ivec[i]) iram_rd_check($sformatf("iram_rd%0d", i), ivec[i].addr, ivec[i].exp_rd);

        foreach (dvec[i]) dram_wr(dvec[i].addr, dvec[i].wdata);
        foreach (dvec[i]) dram_rd_check($sformatf("dram_rd%0d", i), dvec[i].addr, dvec[i].exp_rd);

        // start_2 outranks start_3: this DRAM write must be ignored
        @(negedge clock);
        start_2 = 1'b1; start_3 = 1'b1; dram_write_ext = 1'b1;
        addr_ext = 9'd2; Data_in_dram = 16'h1111;
        @(negedge clock);
        start_2 = 1'b0; start_3 = 1'b0; dram_write_ext = 1'b0;
        dram_rd_check("mode_priority", 9'd2, 16'h8000);

        prog = '{16'h1005, 16'h6000, 16'h1003, 16'h8000,
                 16'h20C8, 16'h4000, 16'hF000, 16'hF000};
        load_prog();
        run_until("p1_halt", 6'd8, 300);
        check("p1_pc", pc_out, 16'd8);
        check("p1_ctrl_halt", control_out, 20'd0);
        check("p1_ac", dram_out, 16'd8);
        @(negedge clock) start = 1'b0;
        dram_rd_check("p1_dram200", 9'd200, 16'd8);

        prog = '{16'h1003, 16'hE000, 16'hD002, 16'h20C9,
                 16'h4000, 16'hF000, 16'hF000, 16'hF000};
        load_prog();
        run_until("loop_halt", 6'd8, 600);
        check("loop_pc", pc_out, 16'd7);
        check("loop_ar", ar_out, 16'd201);
        @(negedge clock) start = 1'b0;
        dram_rd_check("loop_dram201", 9'd201, 16'd0);

        prog = '{16'h112C, 16'h6000, 16'hA000, 16'h20CA,
                 16'h4000, 16'hF000, 16'hF000, 16'hF000};
        load_prog();
        run_until("mul_halt", 6'd8, 300);
        @(negedge clock) start = 1'b0;
`ifdef TOP_CONTROL_MUL_EN
        dram_rd_check("mul_dram202", 9'd202, 16'h5F90);
`else
        dram_rd_check("mul_dram202", 9'd202, 16'd300);
`endif

        dram_wr(9'd203, 16'h1234);
        prog = '{16'h1009, 16'h20CB, 16'h4000, 16'hF000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
        load_prog();
        run_until("reach_mem_wr", 6'd7, 300);
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc_out, 16'd1);
        check("midrst_state", state, 6'd0);
        @(negedge clock);
        start = 1'b0;
        rst_n = 1'b1;
        dram_rd_check("midrst_dram203", 9'd203, 16'h1234);

        prog = '{16'hB001, 16'hF000, 16'hF000, 16'hF000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
        load_prog();
        run_until("spin_decode", 6'd3, 100);
        @(negedge clock);
        start_2 = 1'b1;
        @(negedge clock);
        check("start2_abort_state", state, 6'd0);
        check("start2_abort_pc", pc_out, 16'd1);
        start_2 = 1'b0;
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
